// File: rtl/dmem_ctrl.sv
// dmem_ctrl: core data-memory controller. It decodes single-cycle load/store
// requests onto a word RAM, an LED register, a free-running cycle counter and
// an optional 8N1 serial transmitter.
// Build option: define DMEM_CTRL_TX_EN to include TXDATA/STATUS and the TX FSM.
// Without it, tx idles high and both addresses decode as unmapped.
module dmem_ctrl #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic [7:0]  leds,
  output logic        tx,
  output logic        err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] LED_ADDR = 32'h8000_0000;
  localparam logic [31:0] CYC_ADDR = 32'h8000_0004;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   cycle;
  logic [AW-1:0] idx;
  logic [31:0]   rdata;
  logic          hit_ram, hit_led, hit_cyc, hit_txd, hit_sts, hit_bad;
  logic          tx_busy;
  logic          overrun;

  assign idx = addr[AW+1:2];

  // Address decode: exactly one hit_* flag, or hit_bad for misaligned/unmapped.
  // NOTE: every output of an always_comb gets a value on every path (here all
  // up front), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    hit_ram = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);
    hit_led = (addr == LED_ADDR);
    hit_cyc = (addr == CYC_ADDR);
`ifdef DMEM_CTRL_TX_EN
    hit_txd = (addr == 32'h8000_0008);
    hit_sts = (addr == 32'h8000_000C);
`else
    hit_txd = 1'b0;
    hit_sts = 1'b0;
`endif
    hit_bad = !(hit_ram || hit_led || hit_cyc || hit_txd || hit_sts);
  end

  // Read-data mux; TXDATA and every error case read as zero.
  always_comb begin
    rdata = '0;
    if (hit_ram) begin
      rdata = mem[idx];
    end else if (hit_led) begin
      rdata = {24'h0, leds};
    end else if (hit_cyc) begin
      rdata = cycle;
    end else if (hit_sts) begin
      rdata = {30'h0, overrun, tx_busy};
    end
  end

  // RAM write port; a request that coincides with reset is dropped.
  // NOTE: the array is deliberately left out of reset: contents must survive
  // rst, and a resettable array cannot map onto block RAM. It relies on the
  // device powering RAM up as zero.
  always_ff @(posedge clk) begin
    if (!rst && mem_en && !mem_read && hit_ram) begin
      mem[idx] <= data_out;
    end
  end

  // Load data, LED register, cycle counter and the sticky error flag.
  // NOTE: state is written with <= so every register samples pre-edge values;
  // a blocking = here would leak new values into later statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_in <= '0;
      leds    <= '0;
      cycle   <= '0;
      err     <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (mem_en) begin
        if (mem_read) begin
          data_in <= rdata;
        end else if (hit_led) begin
          leds <= data_out[7:0];
        end else if (hit_cyc) begin
          cycle <= '0;
        end
        if (hit_bad) begin
          err <= 1'b1;
        end
      end
    end
  end

`ifdef DMEM_CTRL_TX_EN
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;
  logic          bit_done;
  logic          txd_wr;

  assign bit_done = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_busy  = (state != IDLE);
  assign txd_wr   = mem_en && !mem_read && hit_txd;

  // Serial TX FSM. tx is a register driven from the pre-edge state, so the
  // line follows the FSM one clock late (start bit begins the edge after the
  // accepting edge). The overrun set is written last so it wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
      tx      <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (mem_en && mem_read && hit_sts) begin
        overrun <= 1'b0;
      end
      if (txd_wr && tx_busy) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (txd_wr) begin
            state   <= START;
            clk_cnt <= '0;
            shifter <= data_out[7:0];
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_done) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          tx <= shifter[0];
          if (bit_done) begin
            clk_cnt <= '0;
            shifter <= shifter >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
`else
  // Bit rate only matters when the transmitter is built.
  logic unused_cfg;
  assign unused_cfg = (CLKS_PER_BIT == 0);
  assign tx         = 1'b1;
  assign tx_busy    = 1'b0;
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked against a transaction-level model.
module tb_dmem_ctrl;

  localparam int DEPTH = 256;
  localparam int CPB   = 4;
  localparam logic [31:0] A_LED = 32'h8000_0000;
  localparam logic [31:0] A_CYC = 32'h8000_0004;
  localparam logic [31:0] A_TXD = 32'h8000_0008;
  localparam logic [31:0] A_STS = 32'h8000_000C;
`ifdef DMEM_CTRL_TX_EN
  localparam bit TX_EN = 1'b1;
`else
  localparam bit TX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, mem_en, mem_read, tx, err;
  logic [31:0] addr, data_out, data_in;
  logic [7:0]  leds;

  dmem_ctrl #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_read(mem_read),
    .addr(addr), .data_out(data_out), .data_in(data_in),
    .leds(leds), .tx(tx), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef enum {K_BAD, K_RAM, K_LED, K_CYC, K_TXD, K_STS} kind_t;

  longint      edge_n = 0;
  longint      m_cyc_zero = 0;          // edge after which CYCLE read 0
  longint      m_start = -1_000_000;    // accepting edge of current frame
  logic [31:0] m_ram [int unsigned];
  logic [31:0] m_data_in = '0;
  logic [7:0]  m_leds = '0;
  logic [7:0]  m_byte = '0;
  logic        m_err = 1'b0;
  logic        m_ovr = 1'b0;

  function automatic kind_t m_kind(input logic [31:0] a);
    if (a % 4 != 0) return K_BAD;
    if (a < DEPTH * 4) return K_RAM;
    if (a == A_LED) return K_LED;
    if (a == A_CYC) return K_CYC;
    if (TX_EN && a == A_TXD) return K_TXD;
    if (TX_EN && a == A_STS) return K_STS;
    return K_BAD;
  endfunction

  // Frame occupies the 10*CPB edges after the accepting edge.
  function automatic bit m_in_frame();
    longint k = edge_n - m_start;
    return TX_EN && k >= 1 && k <= 10 * CPB;
  endfunction

  function automatic logic m_tx();
    longint p;
    if (!m_in_frame()) return 1'b1;
    p = (edge_n - m_start - 1) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_byte[int'(p) - 1];
  endfunction

  task automatic m_apply(input logic r, en, rd, input logic [31:0] a, d);
    bit busy;
    int unsigned w;
    if (r) begin
      m_data_in = '0; m_leds = '0; m_cyc_zero = edge_n;
      m_ovr = 1'b0; m_err = 1'b0; m_start = -1_000_000;
      return;
    end
    if (!en) return;
    busy = m_in_frame();
    w = a / 4;
    case (m_kind(a))
      K_RAM: if (rd) m_data_in = m_ram.exists(w) ? m_ram[w] : 32'h0;
             else m_ram[w] = d;
      K_LED: if (rd) m_data_in = {24'h0, m_leds}; else m_leds = d[7:0];
      K_CYC: if (rd) m_data_in = 32'(edge_n - 1 - m_cyc_zero); else m_cyc_zero = edge_n;
      K_TXD: if (rd) m_data_in = 32'h0;
             else if (busy) m_ovr = 1'b1;
             else begin m_start = edge_n; m_byte = d[7:0]; end
      K_STS: if (rd) begin m_data_in = {30'h0, m_ovr, busy}; m_ovr = 1'b0; end
      default: begin m_err = 1'b1; if (rd) m_data_in = 32'h0; end
    endcase
  endtask

  // One clock: drive, clock, update model, compare all outputs.
  task automatic step(input logic r, en, rd, input logic [31:0] a, d);
    rst = r; mem_en = en; mem_read = rd; addr = a; data_out = d;
    @(posedge clk);
    edge_n++;
    m_apply(r, en, rd, a, d);
    #1;
    check("model data_in", data_in, m_data_in);
    check("model leds", {24'h0, leds}, {24'h0, m_leds});
    check("model err", {31'h0, err}, {31'h0, m_err});
    check("model tx", {31'h0, tx}, {31'h0, m_tx()});
    rst = 1'b0; mem_en = 1'b0; mem_read = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        en;
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] x_data;
    logic [7:0]  x_leds;
    logic        x_err;
  } vec_t;

  function automatic vec_t mk(input string n, input logic en, rd, input logic [31:0] a, d,
                              input logic [31:0] xd, input logic [7:0] xl, input logic xe);
    vec_t v;
    v.name = n; v.en = en; v.rd = rd; v.a = a; v.d = d;
    v.x_data = xd; v.x_leds = xl; v.x_err = xe;
    return v;
  endfunction

  logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    vec_t tbl[$];
    logic [31:0] ra;

    rst = 1'b1; mem_en = 1'b0; mem_read = 1'b0; addr = '0; data_out = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("reset data_in", data_in, 32'h0);
    check("reset leds", {24'h0, leds}, 32'h0);
    check("reset err", {31'h0, err}, 32'h0);
    check("reset tx", {31'h0, tx}, 32'h1);

    tbl.push_back(mk("wr ram 0x10",      1, 0, 32'h10,        32'h1234_5678, 32'h0,         8'h00, 0));
    tbl.push_back(mk("rd ram 0x10",      1, 1, 32'h10,        32'h0,         32'h1234_5678, 8'h00, 0));
    tbl.push_back(mk("wr led",           1, 0, A_LED,         32'h0000_01FF, 32'h1234_5678, 8'hFF, 0));
    tbl.push_back(mk("rd led",           1, 1, A_LED,         32'h0,         32'h0000_00FF, 8'hFF, 0));
    tbl.push_back(mk("rd unwritten",     1, 1, 32'h20,        32'h0,         32'h0,         8'hFF, 0));
    tbl.push_back(mk("wr ram top",       1, 0, 32'h3FC,       32'hDEAD_BEEF, 32'h0,         8'hFF, 0));
    tbl.push_back(mk("rd ram top",       1, 1, 32'h3FC,       32'h0,         32'hDEAD_BEEF, 8'hFF, 0));
    tbl.push_back(mk("no en read",       0, 1, 32'h10,        32'h0,         32'hDEAD_BEEF, 8'hFF, 0));
    tbl.push_back(mk("no en wr led",     0, 0, A_LED,         32'h0,         32'hDEAD_BEEF, 8'hFF, 0));
    tbl.push_back(mk("rd misaligned",    1, 1, 32'h6,         32'h0,         32'h0,         8'hFF, 1));
    tbl.push_back(mk("err sticky",       1, 1, 32'h10,        32'h0,         32'h1234_5678, 8'hFF, 1));
    tbl.push_back(mk("rd unmapped",      1, 1, 32'h4000_0000, 32'h0,         32'h0,         8'hFF, 1));
    tbl.push_back(mk("ram intact",       1, 1, 32'h10,        32'h0,         32'h1234_5678, 8'hFF, 1));
    tbl.push_back(mk("wr past ram",      1, 0, 32'h400,       32'hFFFF_FFFF, 32'h1234_5678, 8'hFF, 1));
    tbl.push_back(mk("no alias word 0",  1, 1, 32'h0,         32'h0,         32'h0,         8'hFF, 1));
    tbl.push_back(mk("rd txdata",        1, 1, A_TXD,         32'h0,         32'h0,         8'hFF, 1));
    tbl.push_back(mk("wr led misalign",  1, 0, 32'h8000_0002, 32'h0,         32'h0,         8'hFF, 1));

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].en, tbl[i].rd, tbl[i].a, tbl[i].d);
      check({tbl[i].name, " data_in"}, data_in, tbl[i].x_data);
      check({tbl[i].name, " leds"}, {24'h0, leds}, {24'h0, tbl[i].x_leds});
      check({tbl[i].name, " err"}, {31'h0, err}, {31'h0, tbl[i].x_err});
    end

    // Request coinciding with reset is discarded
    step(1'b1, 1'b1, 1'b0, A_LED, 32'h55);
    check("rst+wr leds", {24'h0, leds}, 32'h0);
    check("rst clears err", {31'h0, err}, 32'h0);

    // STATUS write
    step(1'b0, 1'b1, 1'b0, A_STS, 32'hFFFF_FFFF);
`ifdef DMEM_CTRL_TX_EN
    check("sts write no err", {31'h0, err}, 32'h0);
`else
    check("sts write unmapped", {31'h0, err}, 32'h1);
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // CYCLE: clear, 10 idle clocks, read
    step(1'b0, 1'b1, 0, A_CYC, 32'hABCD_0123);
    idle(10);
    step(1'b0, 1'b1, 1'b1, A_CYC, 32'h0);
    check("cycle after 10", data_in, 32'd10);
    step(1'b0, 1'b1, 1'b1, A_CYC, 32'h0);
    check("cycle next", data_in, 32'd11);

`ifdef DMEM_CTRL_TX_EN
    // Frame of 0xA5, STATUS polled every clock
    step(1'b0, 1'b1, 1'b0, A_TXD, 32'h0000_00A5);
    check("tx high on accept", {31'h0, tx}, 32'h1);
    for (int k = 1; k <= 44; k++) begin
      step(1'b0, 1'b1, 1'b1, A_STS, 32'h0);
      check("frame tx", {31'h0, tx}, {31'h0, (k <= 40) ? exp_bits[(k - 1) / CPB] : 1'b1});
      check("frame busy", data_in, (k <= 40) ? 32'h1 : 32'h0);
    end

    // Overrun: second write 5 clocks into a frame
    step(1'b0, 1'b1, 1'b0, A_TXD, 32'h0000_003C);
    idle(4);
    step(1'b0, 1'b1, 1'b0, A_TXD, 32'h0000_00FF);
    step(1'b0, 1'b1, 1'b1, A_STS, 32'h0);
    check("status overrun", data_in, 32'h3);
    step(1'b0, 1'b1, 1'b1, A_STS, 32'h0);
    check("status cleared", data_in, 32'h1);
    idle(40);
    step(1'b0, 1'b1, 1'b1, A_STS, 32'h0);
    check("status idle", data_in, 32'h0);
`else
    step(1'b0, 1'b1, 1'b0, A_TXD, 32'h0000_00A5);
    check("txdata unmapped err", {31'h0, err}, 32'h1);
    idle(12);
    check("tx stays high", {31'h0, tx}, 32'h1);
    step(1'b0, 1'b1, 1'b1, A_STS, 32'h0);
    check("status unmapped", data_in, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

    // Reset mid-frame
    step(1'b0, 1'b1, 1'b0, A_LED, 32'h5A);
    step(1'b0, 1'b1, 1'b0, A_TXD, 32'h0000_0081);
    idle(14);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("mid-frame rst tx", {31'h0, tx}, 32'h1);
    check("mid-frame rst leds", {24'h0, leds}, 32'h0);
    check("mid-frame rst err", {31'h0, err}, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
    check("ram kept over rst", data_in, 32'h1234_5678);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3: ra = 32'($urandom_range(0, 15)) << 2;
        4:          ra = 32'((DEPTH - 1) * 4);
        5:          ra = A_LED;
        6:          ra = A_CYC;
        7, 8:       ra = A_TXD;
        9:          ra = A_STS;
        10:         ra = 32'(DEPTH * 4);
        default:    ra = 32'($urandom_range(0, 63)) | 32'h1;
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ra, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
